// File: rtl/display_pkg.sv
// Shared constants for the 8-digit LED scan display: digit count, source codes
// and the active-low g..a segment patterns for hex digits 0..F.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [1:0] SEL_LEDDATA      = 2'd0;
  localparam logic [1:0] SEL_COUNT_ALL    = 2'd1;
  localparam logic [1:0] SEL_COUNT_BRANCH = 2'd2;
  localparam logic [1:0] SEL_COUNT_JMP    = 2'd3;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/led_scan_display.sv
// Snapshots one of four CPU 32-bit words per scan frame and time-multiplexes its
// eight hex nibbles onto a common-anode 8-digit 7-segment display.
module led_scan_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  sel,
  input  logic        hold,
  input  logic [31:0] Leddata,
  input  logic [31:0] Count_all,
  input  logic [31:0] Count_branch,
  input  logic [31:0] Count_jmp,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]            digit_idx_q, digit_idx_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic        tick;
  logic [31:0] src;
  logic [3:0]  nibble;
  logic [6:0]  hex_n;
  logic        blanked;
  logic        dp_n;

  hex7seg u_hex7seg (
    .nibble_i (nibble),
    .seg_n_o  (hex_n)
  );

  always_comb begin
    src = Leddata;
    case (sel)
      SEL_LEDDATA:      src = Leddata;
      SEL_COUNT_ALL:    src = Count_all;
      SEL_COUNT_BRANCH: src = Count_branch;
      SEL_COUNT_JMP:    src = Count_jmp;
      default:          src = Leddata;
    endcase
  end

  // Source is only sampled on the frame wrap, so a mid-frame sel change never tears.
  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    shadow_d    = (tick && (digit_idx_q == 3'd7) && !hold) ? src : shadow_q;
  end

  // A digit above 0 is blank when it and every more-significant nibble are zero.
  always_comb begin
    nibble  = shadow_q[{digit_idx_q, 2'b00} +: 4];
    blanked = BLANK_LZ && (digit_idx_q != 3'd0) &&
              ((shadow_q >> {digit_idx_q, 2'b00}) == 32'd0);
    dp_n    = !((digit_idx_q == 3'd0) && hold);
    an_d    = blanked ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d   = {dp_n, hex_n};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 3'd0;
      shadow_q    <= 32'd0;
      an_q        <= 8'hFE;
      seg_q       <= 8'hC0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_led_scan_display.sv
// Directed bench for led_scan_display (SCAN_DIV=4) with a cycle model feeding an
// expected-output queue; one instance without and one with leading-zero blanking.
module tb_led_scan_display;

  logic        clk = 1'b0;
  logic        clr;
  logic        hold;
  logic [1:0]  sel;
  logic [31:0] leddata, cnt_all, cnt_br, cnt_jmp;
  logic [7:0]  an, seg, an_b, seg_b;

  led_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .clr(clr), .sel(sel), .hold(hold),
    .Leddata(leddata), .Count_all(cnt_all), .Count_branch(cnt_br), .Count_jmp(cnt_jmp),
    .an(an), .seg(seg)
  );

  led_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .clr(clr), .sel(sel), .hold(hold),
    .Leddata(leddata), .Count_all(cnt_all), .Count_branch(cnt_br), .Count_jmp(cnt_jmp),
    .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int          m_div;
  int          m_idx;
  logic [31:0] m_shadow;

  // seg[7:0] with dp off for hex digits 0..F
  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [31:0] model_src();
    case (sel)
      2'd0:    return leddata;
      2'd1:    return cnt_all;
      2'd2:    return cnt_br;
      default: return cnt_jmp;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, want);
  endtask

  task automatic cycle();
    logic [7:0] e_an, e_seg, e_anb;
    logic [3:0] nib;
    logic       blank_b;
    if (clr) begin
      e_an = 8'hFE; e_seg = 8'hC0; e_anb = 8'hFE;
    end else begin
      nib  = m_shadow[m_idx*4 +: 4];
      e_an = 8'hFF;
      e_an[m_idx] = 1'b0;
      e_seg = seg_tab[nib];
      if (m_idx == 0 && hold) e_seg[7] = 1'b0;
      blank_b = (m_idx != 0) && ((m_shadow >> (4 * m_idx)) == 32'd0);
      e_anb = blank_b ? 8'hFF : e_an;
    end
    exp_q.push_back({e_an, e_seg, e_anb, e_seg});
    if (clr) begin
      m_div = 0; m_idx = 0; m_shadow = 32'd0;
    end else if (m_div == 3) begin
      m_div = 0;
      if (m_idx == 7 && !hold) m_shadow = model_src();
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_div++;
    end
    @(posedge clk);
    #1;
    check("scan", {an, seg, an_b, seg_b}, exp_q.pop_front());
  endtask

  task automatic wait_state(input int idx, input int div);
    int budget = 80;
    while (!(m_idx == idx && m_div == div) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $error("FAIL wait_state idx=%0d div=%0d timed out", idx, div);
    end
  endtask

  // Returns right after the edge that puts digit idx on the outputs.
  task automatic wait_slot(input int idx);
    wait_state(idx, 0);
    cycle();
  endtask

  initial begin
    m_div = 0; m_idx = 0; m_shadow = 32'd0;
    clr = 1'b1; hold = 1'b0; sel = 2'd0;
    leddata = 32'h1234_5678; cnt_all = 32'h2222_2222;
    cnt_br = 32'h0000_00A5; cnt_jmp = 32'h0F0F_0F0F;

    // Reset
    cycle();
    check("rst_an", {24'd0, an}, 32'h0000_00FE);
    check("rst_seg", {24'd0, seg}, 32'h0000_00C0);
    cycle();
    check("rst_idx", 32'(dut.digit_idx_q), 32'd0);
    check("rst_div", 32'(dut.div_cnt_q), 32'd0);
    check("rst_shadow", dut.shadow_q, 32'd0);
    clr = 1'b0;

    // Basic scan of 0x12345678 after the first frame wrap
    wait_slot(7);
    wait_slot(0);
    check("scan_d0", {an, seg}, {8'hFE, 8'h80});
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("scan_d0_held", {an, seg}, {8'hFE, 8'h80});
    end
    cycle();
    check("scan_d1", {an, seg}, {8'hFD, 8'hF8});
    wait_slot(3);
    check("scan_d3", {an, seg}, {8'hF7, 8'h92});
    wait_slot(7);
    check("scan_d7", {an, seg}, {8'h7F, 8'hF9});

    // Hold across three wraps, then release
    hold = 1'b1;
    leddata = 32'hDEAD_BEEF;
    for (int f = 0; f < 3; f++) begin
      wait_slot(0);
      check("hold_d0_dp", {an, seg}, {8'hFE, 8'h00});
      wait_slot(3);
      check("hold_d3", {an, seg}, {8'hF7, 8'h92});
    end
    hold = 1'b0;
    wait_slot(0);
    check("release_d0", {an, seg}, {8'hFE, 8'h8E});
    wait_slot(7);
    check("release_d7", {an, seg}, {8'h7F, 8'hA1});

    // Leading-zero blanking with Count_branch = 0xA5
    sel = 2'd2;
    wait_slot(0);
    check("blank_d0", {an_b, seg_b}, {8'hFE, 8'h92});
    wait_slot(1);
    check("blank_d1", {an_b, seg_b}, {8'hFD, 8'h88});
    wait_slot(2);
    check("blank_d2", {24'd0, an_b}, 32'h0000_00FF);
    check("noblank_d2", {an, seg}, {8'hFB, 8'hC0});
    for (int i = 3; i < 8; i++) begin
      wait_slot(i);
      check("blank_hi", {24'd0, an_b}, 32'h0000_00FF);
    end

    // Mid-frame source switch stays invisible until the next wrap
    sel = 2'd0;
    leddata = 32'h1111_1111;
    wait_slot(0);
    check("sw_d0_old", {an, seg}, {8'hFE, 8'hF9});
    wait_slot(3);
    sel = 2'd1;
    wait_slot(5);
    check("sw_d5_old", {an, seg}, {8'hDF, 8'hF9});
    wait_slot(0);
    check("sw_d0_new", {an, seg}, {8'hFE, 8'hA4});
    wait_slot(6);
    check("sw_d6_new", {an, seg}, {8'hBF, 8'hA4});

    // Reset mid-frame at digit 5, div 2
    wait_state(5, 2);
    clr = 1'b1;
    cycle();
    check("mid_rst_idx", 32'(dut.digit_idx_q), 32'd0);
    check("mid_rst_div", 32'(dut.div_cnt_q), 32'd0);
    check("mid_rst_shadow", dut.shadow_q, 32'd0);
    clr = 1'b0;
    cycle();
    check("mid_rst_out", {an, seg}, {8'hFE, 8'hC0});

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel     = 2'($urandom_range(0, 3));
      hold    = ($urandom_range(0, 7) == 0);
      leddata = $urandom();
      cnt_all = $urandom();
      cnt_br  = $urandom_range(0, 1) ? 32'($urandom_range(0, 4095)) : 32'd0;
      cnt_jmp = $urandom();
      clr     = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
